// File: rtl/bus_arbiter_if.sv
// Two-master / one-slave shared bus bundle.
// master modport: arbiter view (it masters the shared slave bus and returns
//                 completions to the requesters).
// slave  modport: environment view (requesters + slave model).
// Signals: mX_req/we/re/addr/wdata/hb -> requests, mX_gnt/err/rdata <- completions,
//          s_* shared bus, s_ack/s_rdata slave reply, timeout sticky flag, err_clr clear.
interface bus_arbiter_if;
  logic        m0_req, m0_we, m0_re;
  logic [31:0] m0_addr, m0_wdata;
  logic [1:0]  m0_hb;
  logic        m0_gnt, m0_err;
  logic [31:0] m0_rdata;

  logic        m1_req, m1_we, m1_re;
  logic [31:0] m1_addr, m1_wdata;
  logic [1:0]  m1_hb;
  logic        m1_gnt, m1_err;
  logic [31:0] m1_rdata;

  logic        s_req, s_we, s_re;
  logic [31:0] s_addr, s_wdata;
  logic [1:0]  s_hb;
  logic        s_ack;
  logic [31:0] s_rdata;

  logic        timeout;
  logic        err_clr;

  modport master (
    input  m0_req, m0_we, m0_re, m0_addr, m0_wdata, m0_hb,
    output m0_gnt, m0_err, m0_rdata,
    input  m1_req, m1_we, m1_re, m1_addr, m1_wdata, m1_hb,
    output m1_gnt, m1_err, m1_rdata,
    output s_req, s_we, s_re, s_addr, s_wdata, s_hb,
    input  s_ack, s_rdata,
    output timeout,
    input  err_clr
  );

  modport slave (
    output m0_req, m0_we, m0_re, m0_addr, m0_wdata, m0_hb,
    input  m0_gnt, m0_err, m0_rdata,
    output m1_req, m1_we, m1_re, m1_addr, m1_wdata, m1_hb,
    input  m1_gnt, m1_err, m1_rdata,
    input  s_req, s_we, s_re, s_addr, s_wdata, s_hb,
    output s_ack, s_rdata,
    input  timeout,
    output err_clr
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter between instruction fetch (M0) and LSU (M1) for one
// shared slave bus, with a per-transaction wait timeout.
// Ports: clk, rst (async active-high), bus (bus_arbiter_if.master).
// Bus outputs and completion pulses are combinational from the owner state
// so a slave ACK completes the master in the same cycle.
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, OWN_M0, OWN_M1} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;      // 1: M1 won last, 0: M0 won last
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             timeout_q, timeout_d;

  logic own, own_m1, timeout_hit, complete, other_req, self_req;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state, bus mux and completion outputs
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    wait_d        = wait_q;
    timeout_d     = timeout_q & ~bus.err_clr;
    bus.s_req     = 1'b0;
    bus.s_we      = 1'b0;
    bus.s_re      = 1'b0;
    bus.s_addr    = '0;
    bus.s_wdata   = '0;
    bus.s_hb      = '0;
    bus.m0_gnt    = 1'b0;
    bus.m0_err    = 1'b0;
    bus.m0_rdata  = '0;
    bus.m1_gnt    = 1'b0;
    bus.m1_err    = 1'b0;
    bus.m1_rdata  = '0;

    own         = (state_q != IDLE);
    own_m1      = (state_q == OWN_M1);
    timeout_hit = own && !bus.s_ack && (wait_q == WAIT_LIMIT);
    complete    = own && (bus.s_ack || timeout_hit);
    other_req   = own_m1 ? bus.m0_req : bus.m1_req;
    self_req    = own_m1 ? bus.m1_req : bus.m0_req;

    case (state_q)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) state_d = last_q ? OWN_M0 : OWN_M1;
        else if (bus.m0_req)          state_d = OWN_M0;
        else if (bus.m1_req)          state_d = OWN_M1;
      end
      OWN_M0, OWN_M1: begin
        bus.s_req   = 1'b1;
        bus.s_we    = own_m1 ? bus.m1_we    : bus.m0_we;
        bus.s_re    = own_m1 ? bus.m1_re    : bus.m0_re;
        bus.s_addr  = own_m1 ? bus.m1_addr  : bus.m0_addr;
        bus.s_wdata = own_m1 ? bus.m1_wdata : bus.m0_wdata;
        bus.s_hb    = own_m1 ? bus.m1_hb    : bus.m0_hb;
        wait_d      = wait_q + CNT_W'(1);
        if (complete) begin
          if (own_m1) begin
            bus.m1_gnt   = 1'b1;
            bus.m1_err   = timeout_hit;
            bus.m1_rdata = bus.s_ack ? bus.s_rdata : '0;
          end else begin
            bus.m0_gnt   = 1'b1;
            bus.m0_err   = timeout_hit;
            bus.m0_rdata = bus.s_ack ? bus.s_rdata : '0;
          end
          // Hand over directly to a waiting peer; otherwise keep or release.
          if (other_req)     state_d = own_m1 ? OWN_M0 : OWN_M1;
          else if (self_req) state_d = state_q;
          else               state_d = IDLE;
        end
        if (timeout_hit) timeout_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Fresh ownership: restart wait count and record the winner
    if (state_d != IDLE && (state_q == IDLE || complete)) begin
      wait_d = '0;
      last_d = (state_d == OWN_M1);
    end
  end

  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: stimulus pushes expected completions into a
// scoreboard queue; a negedge monitor pops and checks every grant.
module tb_bus_arbiter;

  logic clk;
  logic rst;

  bus_arbiter_if bus ();

  bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct packed {
    logic        m1;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic m1, input logic err, input logic [31:0] rdata);
    exp_t e;
    e.m1 = m1; e.err = err; e.rdata = rdata;
    sb_q.push_back(e);
  endtask

  // Monitor: every grant must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m0_gnt && bus.m1_gnt) chk("both_gnt", 32'd1, 32'd0);
      if (bus.m0_gnt || bus.m1_gnt) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_gnt", {31'd0, bus.m1_gnt}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("gnt_owner", {31'd0, bus.m1_gnt}, {31'd0, e.m1});
          chk("gnt_err", {31'd0, e.m1 ? bus.m1_err : bus.m0_err}, {31'd0, e.err});
          chk("gnt_rdata", e.m1 ? bus.m1_rdata : bus.m0_rdata, e.rdata);
        end
      end
      if (!bus.m0_gnt) chk("m0_idle_leak", bus.m0_rdata | {31'd0, bus.m0_err}, 32'd0);
      if (!bus.m1_gnt) chk("m1_idle_leak", bus.m1_rdata | {31'd0, bus.m1_err}, 32'd0);
    end
  end

  initial begin
    rst = 1'b1;
    {bus.m0_req, bus.m0_we, bus.m0_re, bus.m0_hb} = '0;
    {bus.m1_req, bus.m1_we, bus.m1_re, bus.m1_hb} = '0;
    bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_addr = '0; bus.m1_wdata = '0;
    bus.s_ack = 1'b0; bus.s_rdata = '0;
    bus.err_clr = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_s_req", {31'd0, bus.s_req}, 32'd0);
    chk("rst_timeout", {31'd0, bus.timeout}, 32'd0);
    chk("rst_gnt", {30'd0, bus.m1_gnt, bus.m0_gnt}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_s_addr", bus.s_addr, 32'd0);

    // M1 alone: read 0x100, ACK in first owned cycle
    bus.m1_req = 1'b1; bus.m1_re = 1'b1; bus.m1_addr = 32'h100; bus.m1_hb = 2'b10;
    tick();
    chk("m1_s_req", {31'd0, bus.s_req}, 32'd1);
    chk("m1_s_addr", bus.s_addr, 32'h100);
    chk("m1_s_re", {31'd0, bus.s_re}, 32'd1);
    chk("m1_s_hb", {30'd0, bus.s_hb}, 32'd2);
    bus.s_ack = 1'b1; bus.s_rdata = 32'hDEAD_BEEF;
    bus.m1_req = 1'b0;
    push(1'b1, 1'b0, 32'hDEAD_BEEF);
    tick();
    bus.s_ack = 1'b0; bus.m1_re = 1'b0; bus.m1_hb = 2'b00;
    #1;
    chk("m1_back_idle", {31'd0, bus.s_req}, 32'd0);

    // Stray ACK while idle
    bus.s_ack = 1'b1; bus.s_rdata = 32'h0000_0123;
    #1;
    chk("stray_ack_s_req", {31'd0, bus.s_req}, 32'd0);
    tick();
    chk("stray_ack_still_idle", {31'd0, bus.s_req}, 32'd0);
    bus.s_ack = 1'b0;

    // Both from reset, ACK every cycle: M0, M1, M0, M1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.m0_req = 1'b1; bus.m1_req = 1'b1;
    bus.m0_re = 1'b1;  bus.m1_re = 1'b1;
    bus.m0_addr = 32'hA0; bus.m1_addr = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_s_req", {31'd0, bus.s_req}, 32'd1);
      chk("rr_s_addr", bus.s_addr, (i % 2 == 0) ? 32'hA0 : 32'hB0);
      bus.s_ack = 1'b1;
      bus.s_rdata = 32'h1000 + 32'(i);
      push((i % 2) == 1, 1'b0, 32'h1000 + 32'(i));
      if (i == 3) begin
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
      end
    end
    tick();
    bus.s_ack = 1'b0;
    #1;
    chk("rr_end_idle", {31'd0, bus.s_req}, 32'd0);

    // M0 write times out in 4th owned cycle; REQ drop is ignored
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_re = 1'b0;
    bus.m0_addr = 32'h200; bus.m0_wdata = 32'h55; bus.m0_hb = 2'b00;
    tick();
    chk("to_s_we", {31'd0, bus.s_we}, 32'd1);
    chk("to_s_wdata", bus.s_wdata, 32'h55);
    bus.m0_req = 1'b0;
    tick();
    chk("to_req_drop_ignored", {31'd0, bus.s_req}, 32'd1);
    tick();
    tick();
    push(1'b0, 1'b1, 32'd0);
    chk("to_flag_not_yet", {31'd0, bus.timeout}, 32'd0);
    tick();
    chk("to_flag_set", {31'd0, bus.timeout}, 32'd1);
    chk("to_back_idle", {31'd0, bus.s_req}, 32'd0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("to_flag_cleared", {31'd0, bus.timeout}, 32'd0);

    // ACK exactly in the timeout cycle wins
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_re = 1'b1; bus.m0_addr = 32'h300;
    tick();
    bus.m0_req = 1'b0;
    tick();
    tick();
    tick();
    bus.s_ack = 1'b1; bus.s_rdata = 32'hCAFE_F00D;
    push(1'b0, 1'b0, 32'hCAFE_F00D);
    tick();
    bus.s_ack = 1'b0;
    chk("ack_at_limit_no_flag", {31'd0, bus.timeout}, 32'd0);

    // Timeout set beats a simultaneous clear
    bus.m1_req = 1'b1; bus.m1_addr = 32'h400; bus.err_clr = 1'b1;
    tick();
    bus.m1_req = 1'b0;
    tick();
    tick();
    tick();
    push(1'b1, 1'b1, 32'd0);
    tick();
    chk("set_beats_clear", {31'd0, bus.timeout}, 32'd1);
    tick();
    chk("clear_after_set", {31'd0, bus.timeout}, 32'd0);
    bus.err_clr = 1'b0;

    // Back-to-back same master, then round-robin hands conflict to M1
    bus.m0_req = 1'b1; bus.m0_addr = 32'h500;
    tick();
    bus.s_ack = 1'b1; bus.s_rdata = 32'h11;
    push(1'b0, 1'b0, 32'h11);
    tick();
    chk("self_rearb_s_req", {31'd0, bus.s_req}, 32'd1);
    chk("self_rearb_s_addr", bus.s_addr, 32'h500);
    bus.s_rdata = 32'h22;
    push(1'b0, 1'b0, 32'h22);
    bus.m0_req = 1'b0;
    tick();
    bus.s_ack = 1'b0;
    bus.m0_req = 1'b1; bus.m1_req = 1'b1; bus.m1_addr = 32'h600;
    tick();
    chk("rr_after_m0_picks_m1", bus.s_addr, 32'h600);
    bus.s_ack = 1'b1; bus.s_rdata = 32'h33;
    push(1'b1, 1'b0, 32'h33);
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    tick();
    bus.s_ack = 1'b0;

    // Reset while M1 waits for ACK: abort without grant, then M0 wins conflict
    bus.m1_req = 1'b1; bus.m1_addr = 32'h700;
    tick();
    chk("pre_abort_owned", {31'd0, bus.s_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_s_req", {31'd0, bus.s_req}, 32'd0);
    chk("abort_s_addr", bus.s_addr, 32'd0);
    chk("abort_no_gnt", {30'd0, bus.m1_gnt, bus.m0_gnt}, 32'd0);
    tick();
    rst = 1'b0;
    bus.m0_req = 1'b1; bus.m0_addr = 32'h800;
    tick();
    chk("post_abort_m0_wins", bus.s_addr, 32'h800);
    bus.s_ack = 1'b1; bus.s_rdata = 32'h44;
    push(1'b0, 1'b0, 32'h44);
    bus.m0_req = 1'b0;
    tick();
    bus.s_ack = 1'b0; bus.s_rdata = 32'h55;
    push(1'b1, 1'b0, 32'h55);
    bus.s_ack = 1'b1;
    bus.m1_req = 1'b0;
    tick();
    bus.s_ack = 1'b0;

    repeat (2) tick();
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255 (range 2..255): cycles a granted transaction may wait for i_S_ACK before abort.
REQ-002 i_CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 i_RST  in  1  asynchronous, active-high reset.
REQ-004 i_M0_REQ, i_M0_WE, i_M0_RE  in  1 each  master 0 (instruction fetch) request/write/read.
REQ-005 i_M0_ADDR, i_M0_WDATA  in  32 each; i_M0_HB  in  2  (00 byte, 01 half, 10 word).
REQ-006 o_M0_GNT  out  1  one-cycle completion pulse; o_M0_ERR  out  1  valid with GNT; o_M0_RDATA  out  32.
REQ-007 i_M1_* / o_M1_*  identical set for master 1 (LSU).
REQ-008 o_S_REQ, o_S_WE, o_S_RE  out  1; o_S_ADDR, o_S_WDATA  out  32; o_S_HB  out  2  (shared bus).
REQ-009 i_S_ACK  in  1  slave completion; i_S_RDATA  in  32  valid when i_S_ACK=1.
REQ-010 o_TIMEOUT  out  1  sticky timeout flag; i_ERR_CLR  in  1  synchronous clear of o_TIMEOUT.

Function
REQ-011 FSM states IDLE, OWN_M0, OWN_M1; exactly one state active.
REQ-012 IDLE: if exactly one i_Mx_REQ=1, next state OWN_Mx.
REQ-013 IDLE with both requests: winner is the master not in LAST (round-robin); LAST updated to winner on entry to OWN_Mx.
REQ-014 OWN_Mx: o_S_REQ=1 and o_S_WE/RE/ADDR/WDATA/HB combinationally follow master x inputs.
REQ-015 IDLE: o_S_REQ, o_S_WE, o_S_RE, o_S_ADDR, o_S_WDATA, o_S_HB all 0.
REQ-016 OWN_Mx with i_S_ACK=1: o_Mx_GNT=1, o_Mx_ERR=0, o_Mx_RDATA=i_S_RDATA in same cycle.
REQ-017 o_Mx_GNT, o_Mx_ERR 0 and o_Mx_RDATA 0 whenever master x not completing in that cycle.
REQ-018 Minimum latency: REQ sampled at edge N, bus driven from cycle N+1, GNT earliest in cycle N+1.
REQ-019 On ACK in OWN_Mx: if other master's REQ=1, next state OWN_(other) (no IDLE bubble); else if own REQ=1, it re-arbitrates as in REQ-012/013; else IDLE.
REQ-020 Wait counter (8 bit) cleared on entry to any OWN state, +1 each OWN cycle without ACK.
REQ-021 Counter = TIMEOUT_CYCLES-1 with no ACK: o_Mx_GNT=1, o_Mx_ERR=1, o_Mx_RDATA=0, o_TIMEOUT set next edge, next state per REQ-019.
REQ-022 ACK in the timeout cycle takes precedence: normal completion, no error, o_TIMEOUT unchanged.
REQ-023 i_Mx_REQ deassertion while OWN_Mx is ignored; ownership ends only by ACK or timeout.
REQ-024 i_S_ACK in IDLE is ignored; no GNT generated.
REQ-025 i_ERR_CLR and timeout set in same cycle: set wins.
REQ-026 Never both o_M0_GNT and o_M1_GNT high in one cycle.

Reset
REQ-027 i_RST=1 forces immediately: state IDLE, LAST=M1 (M0 wins first conflict), counter 0, o_TIMEOUT 0.
REQ-028 During and after reset all o_* outputs are 0 until the first OWN state.
REQ-029 Reset mid-transaction aborts without GNT; master must re-request.

Verification
REQ-030 M1 alone: REQ=1,RE=1,ADDR=0x100,HB=10; ACK next cycle with RDATA=0xDEADBEEF -> o_S_ADDR=0x100 cycle N+1, o_M1_GNT=1, o_M1_RDATA=0xDEADBEEF, then IDLE.
REQ-031 Both request from reset, ACK every cycle -> grants M0, M1, M0, M1 alternating with no IDLE cycles.
REQ-032 TIMEOUT_CYCLES=4, M0 requests, no ACK -> o_M0_GNT=1,o_M0_ERR=1 in 4th OWN cycle, o_TIMEOUT=1 after; i_ERR_CLR -> 0.
REQ-033 ACK in exact timeout cycle -> o_M0_ERR=0, o_TIMEOUT stays 0.
REQ-034 i_RST asserted while OWN_M1 awaiting ACK -> outputs 0 immediately, no GNT; after release M0/M1 conflict grants M0.
REQ-035 Stray i_S_ACK in IDLE -> no GNT, state stays IDLE.
